// File: rtl/l2_refill_arbiter.sv
// rtl/l2_refill_arbiter.sv - I$/D$ line refill and writeback arbiter toward L2
// One L2 transaction in flight, round-robin grant, FENCE.I discard of in-flight I$ fills.
module l2_refill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    icache_flush_i,
  input  logic                    ic_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ic_req_addr_i,
  output logic                    ic_req_ready_o,
  output logic                    ic_resp_valid_o,
  output logic [LINE_SIZE*8-1:0]  ic_resp_data_o,
  input  logic                    ic_resp_ready_i,
  input  logic                    dc_req_valid_i,
  input  logic                    dc_req_we_i,
  input  logic [ADDR_WIDTH-1:0]   dc_req_addr_i,
  input  logic [LINE_SIZE*8-1:0]  dc_req_wdata_i,
  output logic                    dc_req_ready_o,
  output logic                    dc_resp_valid_o,
  output logic [LINE_SIZE*8-1:0]  dc_resp_data_o,
  input  logic                    dc_resp_ready_i,
  output logic                    l2_req_valid_o,
  input  logic                    l2_req_ready_i,
  output logic                    l2_req_we_o,
  output logic [ADDR_WIDTH-1:0]   l2_req_addr_o,
  output logic [LINE_SIZE*8-1:0]  l2_req_wdata_o,
  input  logic                    l2_resp_valid_i,
  input  logic [LINE_SIZE*8-1:0]  l2_resp_data_i,
  output logic                    l2_resp_ready_o,
  output logic                    busy_o
);

  localparam int DW = LINE_SIZE * 8;
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(LINE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, L2_REQ, L2_WAIT, RESP} state_e;

  state_e                state_q;
  logic                  rr_q;
  logic                  drop_q;
  logic                  owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         rdata_q;
  logic                  ic_resp_valid_q;
  logic                  dc_resp_valid_q;

  logic idle;
  logic ic_elig;
  logic dc_elig;
  logic grant_ic;
  logic grant_dc;
  logic ic_flush_hit;

  // owner_q / rr_q: 0 = I$, 1 = D$
  always_comb begin
    idle         = (state_q == IDLE) && !rst_i;
    ic_elig      = ic_req_valid_i && !icache_flush_i;
    dc_elig      = dc_req_valid_i;
    grant_ic     = idle && ic_elig && (!dc_elig || !rr_q);
    grant_dc     = idle && dc_elig && !grant_ic;
    ic_flush_hit = icache_flush_i && !owner_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rr_q            <= 1'b0;
      drop_q          <= 1'b0;
      owner_q         <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ic || grant_dc) begin
            owner_q <= grant_dc;
            we_q    <= grant_dc && dc_req_we_i;
            addr_q  <= (grant_dc ? dc_req_addr_i : ic_req_addr_i) & ~OFFS_MASK;
            wdata_q <= grant_dc ? dc_req_wdata_i : '0;
            rr_q    <= grant_ic;
            drop_q  <= 1'b0;
            state_q <= L2_REQ;
          end
        end
        L2_REQ: begin
          if (ic_flush_hit) drop_q <= 1'b1;
          if (l2_req_ready_i) state_q <= L2_WAIT;
        end
        L2_WAIT: begin
          // A flush landing together with the response still discards it
          if (l2_resp_valid_i) begin
            if (drop_q || ic_flush_hit) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              rdata_q         <= we_q ? '0 : l2_resp_data_i;
              ic_resp_valid_q <= !owner_q;
              dc_resp_valid_q <= owner_q;
              state_q         <= RESP;
            end
          end else if (ic_flush_hit) begin
            drop_q <= 1'b1;
          end
        end
        RESP: begin
          if ((owner_q ? dc_resp_ready_i : ic_resp_ready_i) || ic_flush_hit) begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_req_ready_o  = grant_ic;
  assign dc_req_ready_o  = grant_dc;
  assign l2_req_valid_o  = (state_q == L2_REQ);
  assign l2_req_we_o     = l2_req_valid_o && we_q;
  assign l2_req_addr_o   = l2_req_valid_o ? addr_q : '0;
  assign l2_req_wdata_o  = l2_req_valid_o ? wdata_q : '0;
  assign l2_resp_ready_o = (state_q == L2_WAIT);
  assign ic_resp_valid_o = ic_resp_valid_q;
  assign ic_resp_data_o  = ic_resp_valid_q ? rdata_q : '0;
  assign dc_resp_valid_o = dc_resp_valid_q;
  assign dc_resp_data_o  = dc_resp_valid_q ? rdata_q : '0;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// tb/tb_l2_refill_arbiter.sv - self-checking bench for l2_refill_arbiter
// Transaction-record reference model compared on every falling edge, plus directed literal checks.
module tb_l2_refill_arbiter;
  localparam int AW = 32;
  localparam int LS = 64;
  localparam int DW = LS * 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          icache_flush_i = 1'b0;
  logic          ic_req_valid_i = 1'b0;
  logic [AW-1:0] ic_req_addr_i = '0;
  logic          ic_req_ready_o;
  logic          ic_resp_valid_o;
  logic [DW-1:0] ic_resp_data_o;
  logic          ic_resp_ready_i = 1'b1;
  logic          dc_req_valid_i = 1'b0;
  logic          dc_req_we_i = 1'b0;
  logic [AW-1:0] dc_req_addr_i = '0;
  logic [DW-1:0] dc_req_wdata_i = '0;
  logic          dc_req_ready_o;
  logic          dc_resp_valid_o;
  logic [DW-1:0] dc_resp_data_o;
  logic          dc_resp_ready_i = 1'b1;
  logic          l2_req_valid_o;
  logic          l2_req_ready_i = 1'b0;
  logic          l2_req_we_o;
  logic [AW-1:0] l2_req_addr_o;
  logic [DW-1:0] l2_req_wdata_o;
  logic          l2_resp_valid_i = 1'b0;
  logic [DW-1:0] l2_resp_data_i = '0;
  logic          l2_resp_ready_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  l2_refill_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .icache_flush_i(icache_flush_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o), .ic_resp_ready_i(ic_resp_ready_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_we_i(dc_req_we_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_wdata_i(dc_req_wdata_i), .dc_req_ready_o(dc_req_ready_o),
    .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o), .dc_resp_ready_i(dc_resp_ready_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_we_o(l2_req_we_o),
    .l2_req_addr_o(l2_req_addr_o), .l2_req_wdata_o(l2_req_wdata_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i), .l2_resp_ready_o(l2_resp_ready_o),
    .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: one transaction record (have/sent/got) instead of a state machine
  bit            m_have, m_sent, m_got, m_drop, m_own, m_rr, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  initial begin
    m_have = 0; m_sent = 0; m_got = 0; m_drop = 0; m_own = 0; m_rr = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  end

  always @(negedge clk_i) begin : compare
    logic win_ic, win_dc, e_l2v, e_icv, e_dcv, fl;
    win_ic = !rst_i && !m_have && ic_req_valid_i && !icache_flush_i && (!dc_req_valid_i || !m_rr);
    win_dc = !rst_i && !m_have && dc_req_valid_i && !win_ic;
    e_l2v  = !rst_i && m_have && !m_sent;
    e_icv  = !rst_i && m_have && m_got && !m_own;
    e_dcv  = !rst_i && m_have && m_got && m_own;
    chk1("ic_req_ready", ic_req_ready_o, win_ic);
    chk1("dc_req_ready", dc_req_ready_o, win_dc);
    chk1("l2_req_valid", l2_req_valid_o, e_l2v);
    chk1("l2_req_we", l2_req_we_o, e_l2v && m_we);
    chkw("l2_req_addr", DW'(l2_req_addr_o), e_l2v ? DW'(m_addr) : '0);
    chkw("l2_req_wdata", l2_req_wdata_o, e_l2v ? m_wdata : '0);
    chk1("l2_resp_ready", l2_resp_ready_o, !rst_i && m_have && m_sent && !m_got);
    chk1("ic_resp_valid", ic_resp_valid_o, e_icv);
    chkw("ic_resp_data", ic_resp_data_o, e_icv ? m_rdata : '0);
    chk1("dc_resp_valid", dc_resp_valid_o, e_dcv);
    chkw("dc_resp_data", dc_resp_data_o, e_dcv ? m_rdata : '0);
    chk1("busy", busy_o, !rst_i && m_have);

    fl = icache_flush_i && !m_own;
    if (rst_i) begin
      m_have = 0; m_drop = 0; m_rr = 0;
    end else if (win_ic || win_dc) begin
      m_have  = 1; m_sent = 0; m_got = 0; m_drop = 0;
      m_own   = win_dc;
      m_we    = win_dc && dc_req_we_i;
      m_addr  = ((win_dc ? dc_req_addr_i : ic_req_addr_i) / AW'(LS)) * AW'(LS);
      m_wdata = win_dc ? dc_req_wdata_i : '0;
      m_rr    = win_dc ? 1'b0 : 1'b1;
    end else if (m_have) begin
      if (!m_sent) begin
        if (fl) m_drop = 1;
        if (l2_req_ready_i) m_sent = 1;
      end else if (!m_got) begin
        if (l2_resp_valid_i) begin
          if (m_drop || fl) begin m_have = 0; m_drop = 0; end
          else begin m_got = 1; m_rdata = m_we ? '0 : l2_resp_data_i; end
        end else if (fl) m_drop = 1;
      end else if (fl || (m_own ? dc_resp_ready_i : ic_resp_ready_i)) begin
        m_have = 0;
      end
    end
  end

  int            n_icv = 0, n_ic_hs = 0, n_dc_hs = 0;
  logic [DW-1:0] last_ic_data = '0;

  always @(negedge clk_i) begin
    if (ic_resp_valid_o) begin
      n_icv++;
      last_ic_data = ic_resp_data_o;
      if (ic_resp_ready_i) n_ic_hs++;
    end
    if (dc_resp_valid_o && dc_resp_ready_i) n_dc_hs++;
  end

  // L2 responder: ready after req_delay cycles, data after resp_delay cycles
  int            req_delay = 0, resp_delay = 0;
  bit            use_pat = 0;
  logic [DW-1:0] resp_pat = '0;

  initial begin : l2_side
    int phase, cnt;
    logic [AW-1:0] seen;
    phase = 0; cnt = 0; seen = '0;
    forever begin
      @(posedge clk_i); #2;
      l2_req_ready_i = 1'b0; l2_resp_valid_i = 1'b0; l2_resp_data_i = '0;
      if (rst_i) begin
        phase = 0; cnt = 0;
      end else if (phase == 0 && l2_req_valid_o) begin
        if (cnt >= req_delay) begin l2_req_ready_i = 1'b1; seen = l2_req_addr_o; phase = 1; cnt = 0; end
        else cnt++;
      end else if (phase == 1 && l2_resp_ready_o) begin
        if (cnt >= resp_delay) begin
          l2_resp_valid_i = 1'b1;
          l2_resp_data_i  = use_pat ? resp_pat : {16{seen}};
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_grant(input bit dc, input string name);
    bit found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk_i);
      found = dc ? dc_req_ready_o : ic_req_ready_o;
    end
    chk1({name, "_granted"}, found, 1'b1);
    step();
    if (dc) dc_req_valid_i = 1'b0; else ic_req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk_i);
      idle = !busy_o;
    end
    chk1({name, "_idle"}, idle, 1'b1);
  endtask

  task automatic wait_l2_wait(input string name);
    bit found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk_i);
      found = l2_resp_ready_o;
    end
    chk1({name, "_in_wait"}, found, 1'b1);
  endtask

  initial begin : main
    int m, rv, l2v, n;
    bit seen, done, hs;
    int order[$];

    // reset state
    @(negedge clk_i);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_l2_req_valid", l2_req_valid_o, 1'b0);
    chkw("rst_ic_resp_data", ic_resp_data_o, '0);
    step(); step(); rst_i = 1'b0;

    // single I$ refill; flush makes I$ ineligible for a cycle
    step(); icache_flush_i = 1'b1; ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_1234;
    @(negedge clk_i); chk1("t1_flush_blocks_ic", ic_req_ready_o, 1'b0);
    step(); icache_flush_i = 1'b0; use_pat = 1; resp_pat = {64{8'hA5}}; resp_delay = 3;
    n_dc_hs = 0;
    @(negedge clk_i); chk1("t1_grant", ic_req_ready_o, 1'b1);
    step(); ic_req_valid_i = 1'b0;
    @(negedge clk_i);
    chk1("t1_l2v_next_cycle", l2_req_valid_o, 1'b1);
    chkw("t1_addr_aligned", DW'(l2_req_addr_o), DW'(32'h0000_1200));
    chk1("t1_we", l2_req_we_o, 1'b0);
    m = -100; seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (l2_resp_valid_i && l2_resp_ready_o) m = c;
      if (ic_resp_valid_o && !seen) begin
        seen = 1;
        chki("t1_resp_latency", c, m + 1);
        chkw("t1_resp_data", ic_resp_data_o, {64{8'hA5}});
      end
    end
    chk1("t1_resp_seen", seen, 1'b1);
    chki("t1_dc_quiet", n_dc_hs, 0);
    use_pat = 0; resp_delay = 1;

    // contention from reset: grants alternate I$, D$, I$, D$
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_0100;
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b0; dc_req_addr_i = 32'h2000_0080;
    n_ic_hs = 0; n_dc_hs = 0; n = 0;
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge clk_i);
      if (ic_req_ready_o) begin order.push_back(0); n++; end
      if (dc_req_ready_o) begin order.push_back(1); n++; end
    end
    step(); ic_req_valid_i = 1'b0; dc_req_valid_i = 1'b0;
    wait_idle("t2");
    chki("t2_grants", n, 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chki("t2_grant_order", order[i], i % 2);
    chki("t2_ic_resps", n_ic_hs, 2);
    chki("t2_dc_resps", n_dc_hs, 2);

    // D$ writeback returns a zero-data ack
    step(); dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1; dc_req_addr_i = 32'h8000_0040;
    dc_req_wdata_i = {8{64'h0123_4567_89AB_CDEF}};
    wait_grant(1, "t3");
    seen = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk_i);
      if (l2_req_valid_o && !seen) begin
        seen = 1;
        chk1("t3_we", l2_req_we_o, 1'b1);
        chkw("t3_addr", DW'(l2_req_addr_o), DW'(32'h8000_0040));
        chkw("t3_wdata", l2_req_wdata_o, {8{64'h0123_4567_89AB_CDEF}});
      end
      if (dc_resp_valid_o) begin done = 1; chkw("t3_ack_data", dc_resp_data_o, '0); end
    end
    chk1("t3_ack_seen", done, 1'b1);
    dc_req_we_i = 1'b0;
    wait_idle("t3");

    // backpressure on both the L2 request and the D$ response
    step(); req_delay = 5; dc_resp_ready_i = 1'b0;
    dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h0000_3FC7;
    wait_grant(1, "t4");
    rv = 0; l2v = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (l2_req_valid_o) begin
        l2v++;
        chkw("t4_addr_hold", DW'(l2_req_addr_o), DW'(32'h0000_3FC0));
      end
      if (dc_resp_valid_o) begin
        rv++;
        if (rv == 4) begin step(); dc_resp_ready_i = 1'b1; end
      end else if (rv > 0) done = 1;
    end
    chki("t4_l2v_cycles", l2v, 6);
    chki("t4_resp_hold", rv, 5);
    req_delay = 0;

    // FENCE.I while the I$ fill waits on L2; pending D$ request follows
    step(); resp_delay = 4; n_icv = 0;
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_0A00;
    wait_grant(0, "t5");
    dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h0000_0B00;
    wait_l2_wait("t5");
    step(); icache_flush_i = 1'b1;
    step(); icache_flush_i = 1'b0;
    hs = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk_i);
      if (hs) begin
        chk1("t5_busy_drop", busy_o, 1'b0);
        chk1("t5_dc_granted", dc_req_ready_o, 1'b1);
        done = 1;
      end else if (l2_resp_valid_i && l2_resp_ready_o) hs = 1;
    end
    chk1("t5_resp_consumed", hs, 1'b1);
    step(); dc_req_valid_i = 1'b0;
    wait_idle("t5");
    chki("t5_no_ic_fill", n_icv, 0);

    // asynchronous reset in L2_WAIT, then a normal I$ refill
    step(); resp_delay = 6;
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_0C40;
    wait_grant(0, "t6");
    wait_l2_wait("t6");
    step(); rst_i = 1'b1;
    @(negedge clk_i);
    chk1("t6_rst_busy", busy_o, 1'b0);
    chk1("t6_rst_l2_resp_ready", l2_resp_ready_o, 1'b0);
    step(); step(); rst_i = 1'b0; resp_delay = 1; n_icv = 0;
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_0D00;
    wait_grant(0, "t6b");
    wait_idle("t6b");
    chki("t6_one_fill", n_icv, 1);
    chkw("t6_fill_data", last_ic_data, {16{32'h0000_0D00}});

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/l2_refill_arbiter.md
Name: l2_refill_arbiter

Overview:
- Arbitrates line-granularity L2 traffic between the instruction cache (I$, requester 0) and the data cache (D$, requester 1).
- Handles I$ refill reads, D$ refill reads and D$ dirty-line writebacks.
- Keeps exactly one transaction outstanding to L2 at a time and routes each response back to the requester that owns it.
- Sits between the L1 caches and the L2$ request/response channel. Provides round-robin fairness and FENCE.I-safe discard of in-flight I$ fills.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- LINE_SIZE, 64, cache line size in bytes. Line data width is LINE_SIZE*8.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- icache_flush_i  in  1  FENCE.I pulse from I$ control.
- ic_req_valid_i  in  1  I$ refill request valid.
- ic_req_addr_i  in  ADDR_WIDTH  I$ line address. Low $clog2(LINE_SIZE) bits are ignored and forced to 0 toward L2.
- ic_req_ready_o  out  1  I$ request accepted.
- ic_resp_valid_o  out  1  I$ fill data valid.
- ic_resp_data_o  out  LINE_SIZE*8  I$ fill line.
- ic_resp_ready_i  in  1  I$ accepts the fill.
- dc_req_valid_i  in  1  D$ request valid.
- dc_req_we_i  in  1  1 = writeback, 0 = refill.
- dc_req_addr_i  in  ADDR_WIDTH  D$ line address, aligned the same way as ic_req_addr_i.
- dc_req_wdata_i  in  LINE_SIZE*8  writeback line.
- dc_req_ready_o  out  1  D$ request accepted.
- dc_resp_valid_o  out  1  D$ fill data valid, or write ack.
- dc_resp_data_o  out  LINE_SIZE*8  D$ fill line. 0 for write acks.
- dc_resp_ready_i  in  1  D$ accepts the response.
- l2_req_valid_o  out  1  request to L2.
- l2_req_ready_i  in  1  L2 accepts the request.
- l2_req_we_o  out  1  write flag.
- l2_req_addr_o  out  ADDR_WIDTH  line-aligned address.
- l2_req_wdata_o  out  LINE_SIZE*8  write data.
- l2_resp_valid_i  in  1  L2 response valid.
- l2_resp_data_i  in  LINE_SIZE*8  L2 read line.
- l2_resp_ready_o  out  1  arbiter accepts the L2 response.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset: asynchronous on rst_i high.
  - State = IDLE, rr_ptr = 0 (I$ favoured), drop = 0.
  - All outputs = 0, including all data buses.
  - Reset mid-transaction abandons it. No L2 handshake is completed.
- State machine: IDLE -> L2_REQ -> L2_WAIT -> RESP -> IDLE. A dropped transaction goes L2_WAIT -> IDLE.
- IDLE:
  - ic_req_ready_o and dc_req_ready_o are combinational. At most one is high: the winner.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: the requester selected by rr_ptr.
  - I$ is not eligible in a cycle where icache_flush_i = 1.
  - On the valid&&ready edge:
    - latch owner, we (forced 0 for I$), aligned address and wdata;
    - set rr_ptr to the other requester;
    - go to L2_REQ.
- L2_REQ:
  - l2_req_valid_o = 1, with we/addr/wdata driven from the latched registers and held stable until l2_req_ready_i.
  - On l2_req_ready_i, go to L2_WAIT.
- L2_WAIT:
  - l2_resp_ready_o = 1.
  - On l2_resp_valid_i with drop = 1: clear drop, go to IDLE, discard the data.
  - On l2_resp_valid_i with drop = 0: register the data (0 if we = 1), go to RESP.
- RESP:
  - The owner's resp_valid_o = 1 with the registered data, held until that owner's resp_ready_i.
  - On resp_ready_i, drop resp_valid_o and go to IDLE.
  - The other requester's resp_valid_o stays 0.
- Flush handling:
  - icache_flush_i while owner = I$ in L2_REQ or L2_WAIT sets drop. The L2 handshake still completes; the data is discarded.
  - icache_flush_i while owner = I$ in RESP: deassert ic_resp_valid_o next cycle and go to IDLE.
  - A flush has no effect on D$-owned transactions.
- Latency:
  - Request accepted at cycle N -> l2_req_valid_o high at N+1.
  - l2_resp_valid_i at cycle M -> owner resp_valid_o at M+1.
  - Earliest next grant is the cycle after the response handshake. There is no bypass.
- Simultaneous events:
  - A request arriving while busy waits, with ready = 0. The requester must hold valid and payload.
  - rr_ptr changes only on a grant. A lone requester never starves, and alternating is guaranteed under contention.

Test Plan:
- Single I$ refill: ic addr 0x0000_1234, L2 ready immediately, response 0xA5.. after 3 cycles. Required: l2_req_addr_o = 0x0000_1200 with we = 0; ic_resp_valid_o one cycle after the L2 response, data = 0xA5..; dc_resp_valid_o stays 0.
- Contention: both valid continuously from reset. Grants alternate I$, D$, I$, D$. Each owner gets exactly its own response; 4 transactions complete in order.
- D$ writeback: we = 1, addr 0x8000_0040, wdata pattern. Required: l2_req_we_o = 1 and wdata matches; dc_resp_valid_o is a write ack with data 0.
- Backpressure: l2_req_ready_i low for 5 cycles, then dc_resp_ready_i low for 4 cycles. Required: request fields stay stable throughout; resp_valid is held until ready.
- FENCE.I during L2_WAIT on an I$ fill. Required: L2 response consumed (l2_resp_ready_o = 1); ic_resp_valid_o never asserts; busy_o drops the next cycle; a pending D$ request is granted after that.
- Reset asserted in L2_WAIT. Required: all outputs 0 immediately (asynchronous); after release, a new I$ request is served normally.
